// File: rtl/apb_arb_pkg.sv
// Shared state encoding, default widths and round-robin helper for apb_req_arbiter.
package apb_arb_pkg;

    localparam int DEF_NREQ    = 2;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_TIMEOUT = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    function automatic int rr_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/apb_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   idx,
    output logic            any
);

    logic [IW-1:0] k;

    // Walk offsets high to low so the smallest offset from ptr is written last and wins.
    always_comb begin
        idx = '0;
        k   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = IW'((int'(ptr) + i) % NREQ);
            if (req[k]) idx = k;
        end
    end

    assign any = |req;

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master port among NREQ requesters.
// Define APB_TIMEOUT_EN to abort an ACCESS phase after TIMEOUT cycles without PREADY.
import apb_arb_pkg::*;

module apb_req_arbiter #(
    parameter int NREQ    = DEF_NREQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                     PCLK,
    input  logic                     PRESETn,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_write,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          req_done,
    output logic [DATA_W-1:0]        req_rdata,
    output logic                     req_err,
    output logic                     busy,
    output logic                     PSEL,
    output logic                     PENABLE,
    output logic                     PWRITE,
    output logic [ADDR_W-1:0]        PADDR,
    output logic [DATA_W-1:0]        PWDATA,
    input  logic [DATA_W-1:0]        PRDATA,
    input  logic                     PREADY,
    input  logic                     PSLVERR
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e                      state_q, state_d;
    logic [IW-1:0]               ptr_q, ptr_d, win_q, win_d;
    logic                        psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]           paddr_q, paddr_d;
    logic [DATA_W-1:0]           pwdata_q, pwdata_d, rdata_q, rdata_d;
    logic [NREQ-1:0]             done_q, done_d;
    logic                        err_q, err_d;

    logic [NREQ-1:0][ADDR_W-1:0] addr_a;
    logic [NREQ-1:0][DATA_W-1:0] wdata_a;
    logic [NREQ-1:0]             win_oh, pick_req;
    logic [IW-1:0]               pick_idx;
    logic                        pick_any, expire, grant;

    assign addr_a  = req_addr;
    assign wdata_a = req_wdata;

    // One picker serves both IDLE arbitration and the back-to-back decision,
    // where the finishing winner is masked out.
    always_comb begin
        win_oh        = '0;
        win_oh[win_q] = 1'b1;
        pick_req      = (state_q == ST_ACCESS) ? (req_valid & ~win_oh) : req_valid;
    end

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req (pick_req),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

`ifdef APB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;

    always_comb begin
        tmo_d  = '0;
        if (state_q == ST_ACCESS && !PREADY) tmo_d = tmo_q + TW'(1);
        expire = (state_q == ST_ACCESS) && !PREADY && (tmo_q == TW'(TIMEOUT - 1));
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) tmo_q <= '0;
        else          tmo_q <= tmo_d;
    end
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        done_d    = '0;
        rdata_d   = '0;
        err_d     = 1'b0;
        grant     = 1'b0;
        unique case (state_q)
            ST_IDLE: grant = pick_any;
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY || expire) begin
                    done_d    = win_oh;
                    rdata_d   = (PREADY && !pwrite_q) ? PRDATA : '0;
                    err_d     = PREADY ? PSLVERR : 1'b1;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    state_d   = ST_IDLE;
                    grant     = PREADY && pick_any;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (grant) begin
            win_d     = pick_idx;
            ptr_d     = IW'(rr_inc(int'(pick_idx), NREQ));
            pwrite_d  = req_write[pick_idx];
            paddr_d   = addr_a[pick_idx];
            pwdata_d  = wdata_a[pick_idx];
            psel_d    = 1'b1;
            penable_d = 1'b0;
            state_d   = ST_SETUP;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            win_q     <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            done_q    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign req_done  = done_q;
    assign req_rdata = rdata_q;
    assign req_err   = err_q;
    assign busy      = psel_q;

endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
Round-robin scheduler that shares one APB master port between NREQ local requesters (CPU-side tasks, DMA, debug).
- Accepts simple valid/done transaction requests.
- Sequences the APB SETUP/ACCESS phases toward the slave register file.
- Honours PREADY wait states and returns read data and error status to the winning requester.

Parameters:
NREQ, 2, number of requesters (2..8)
ADDR_W, 8, APB address width
DATA_W, 8, APB data width
TIMEOUT, 16, max ACCESS cycles before abort (used only with APB_TIMEOUT_EN)

Ports:
PCLK  in  1  clock, all logic on rising edge
PRESETn  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester transaction request
req_write  in  NREQ  per-requester direction, 1=write
req_addr  in  NREQ*ADDR_W  flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NREQ*DATA_W  flattened write data, same packing
req_done  out  NREQ  one-cycle completion pulse to the granted requester
req_rdata  out  DATA_W  read data, valid while req_done is high
req_err  out  1  error status, valid while req_done is high
busy  out  1  high in SETUP or ACCESS
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_W  APB address
PWDATA  out  DATA_W  APB write data
PRDATA  in  DATA_W  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB slave error

Behaviour:
- Reset (async, PRESETn=0):
  - All outputs are 0.
  - state=IDLE; round-robin pointer=0, so requester 0 has highest priority.
- All APB outputs are registered.
- Grant:
  - In IDLE, if any req_valid is high, choose the first set bit searching upward from the pointer, wrapping modulo NREQ.
  - Latch that requester's write/addr/wdata into PWRITE/PADDR/PWDATA.
  - Set pointer to winner+1 (mod NREQ) and move to SETUP.
  - Request fields are sampled only at grant. Later changes are ignored.
- SETUP (exactly one cycle): PSEL=1, PENABLE=0 → ACCESS.
- ACCESS: PSEL=1, PENABLE=1. Stay while PREADY=0; PADDR/PWDATA/PWRITE hold stable.
- Completion, on the edge where PENABLE=1 and PREADY=1:
  - Next cycle: req_done[winner]=1 for exactly one cycle.
  - req_rdata = captured PRDATA on a read, 0 on a write.
  - req_err = captured PSLVERR.
- Back-to-back:
  - In the completion cycle, arbitrate over req_valid with the winner's bit masked. If any remain, go directly to SETUP with the new fields, with no idle cycle.
  - Otherwise go to IDLE and drop PSEL and PENABLE.
- Requester protocol:
  - Hold req_valid until req_done, then deassert within one cycle.
  - A req_valid that is still high in IDLE after its own done is treated as a new request.
- Minimum latency, req_valid in IDLE to req_done: 4 cycles with PREADY=1 (grant → SETUP → ACCESS → done).
- PENABLE never rises without a preceding SETUP cycle. PSEL=0 implies PENABLE=0.
- Reset asserted mid-transaction:
  - Immediate abort, all outputs 0, no req_done pulse.
  - After release, arbitration restarts at requester 0.
- Simultaneous requests: strictly round-robin. No requester is granted twice while another is continuously requesting.

Optional Feature:
APB_TIMEOUT_EN
- When defined:
  - A counter runs during ACCESS.
  - If PREADY stays 0 for TIMEOUT consecutive ACCESS cycles, drop PSEL/PENABLE and go to IDLE.
  - Pulse req_done[winner] with req_err=1 and req_rdata=0.
  - Ignore any PREADY arriving after the abort.
- When undefined: no counter, and ACCESS waits indefinitely for PREADY.

Decomposition:
- Package apb_arb_pkg:
  - state encoding IDLE/SETUP/ACCESS
  - default width constants
  - function for round-robin index increment modulo NREQ
- Sub-module rr_pick:
  - combinational; inputs NREQ request vector and pointer
  - outputs winner index and any-valid flag
  - instantiated once; the masked back-to-back vector is fed through the same instance via a mux.

Test Plan:
- Requester 0 writes addr 0x00 data 0xAA, PREADY=1 → SETUP at cycle 2, ACCESS at cycle 3, req_done[0] at cycle 4, PWDATA=0xAA, req_err=0.
- Requester 1 reads addr 0x03, PRDATA=0xDD, PREADY low for 3 ACCESS cycles → ACCESS lasts 4 cycles with PADDR stable, req_rdata=0xDD on req_done[1].
- Both requesters valid continuously at reset release → grants 0,1,0,1, with no IDLE between transfers and each PSEL high through back-to-back transfers.
- Read with PSLVERR=1 at completion → req_err=1 on done; next transfer's req_err=0.
- PRESETn pulsed low during ACCESS → outputs 0 asynchronously, no req_done; after release requester 0 is granted first.
- APB_TIMEOUT_EN with TIMEOUT=16 and PREADY held 0 → abort after 16 ACCESS cycles, req_done with req_err=1 and req_rdata=0. Without the macro, the bench waits indefinitely.
